// File: rtl/updown_counter_mux_sseg.sv
// Up/down counter (load, modulus, wrap/saturate) driving a multiplexed hex seven-segment display.
// Optional macro SSEG_LEADING_BLANK_EN blanks leading zero digits (digit 0 always shown).
module updown_counter_mux_sseg #(
   parameter int unsigned           WIDTH    = 8,
   parameter logic [WIDTH-1:0]      MAX_VAL  = {WIDTH{1'b1}},
   parameter int unsigned           DIGITS   = 2,
   parameter int unsigned           SCAN_DIV = 16
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              enable_i,
   input  logic              mode_i,
   input  logic              sat_i,
   input  logic              load_en_i,
   input  logic [WIDTH-1:0]  load_i,
   output logic [WIDTH-1:0]  cnt_o,
   output logic              tc_o,
   output logic [DIGITS-1:0] dig_sel_o,
   output logic [7:0]        sseg_o
);

   localparam int unsigned PRE_W = $clog2(SCAN_DIV);
   localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int unsigned NIB_W = DIGITS * 4;

   logic [WIDTH-1:0]  cnt_q, cnt_d;
   logic              tc_q, tc_d;
   logic [PRE_W-1:0]  presc_q, presc_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [DIGITS-1:0] dig_sel_q, dig_sel_d;
   logic [7:0]        sseg_q, sseg_d;
   logic [NIB_W-1:0]  padded_s;
   logic [3:0]        nibble_s;

   function automatic logic [7:0] hex_to_sseg(input logic [3:0] nib);
      case (nib)
         4'h0:    hex_to_sseg = 8'b11111100;
         4'h1:    hex_to_sseg = 8'b01100000;
         4'h2:    hex_to_sseg = 8'b11011010;
         4'h3:    hex_to_sseg = 8'b11110010;
         4'h4:    hex_to_sseg = 8'b01100110;
         4'h5:    hex_to_sseg = 8'b10110110;
         4'h6:    hex_to_sseg = 8'b10111110;
         4'h7:    hex_to_sseg = 8'b11100000;
         4'h8:    hex_to_sseg = 8'b11111110;
         4'h9:    hex_to_sseg = 8'b11110110;
         4'hA:    hex_to_sseg = 8'b11101110;
         4'hB:    hex_to_sseg = 8'b00111110;
         4'hC:    hex_to_sseg = 8'b00011010;
         4'hD:    hex_to_sseg = 8'b01111010;
         4'hE:    hex_to_sseg = 8'b10011110;
         4'hF:    hex_to_sseg = 8'b10001110;
         default: hex_to_sseg = 8'b00000000;
      endcase
   endfunction

   // Counter next state: load beats step, tc flags a step taken from a bound.
   always_comb begin
      cnt_d = cnt_q;
      tc_d  = 1'b0;
      if (load_en_i) begin
         cnt_d = (load_i > MAX_VAL) ? MAX_VAL : load_i;
      end else if (enable_i) begin
         if (mode_i) begin
            if (cnt_q < MAX_VAL) begin
               cnt_d = cnt_q + WIDTH'(1);
            end else begin
               tc_d  = 1'b1;
               cnt_d = sat_i ? MAX_VAL : '0;
            end
         end else begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - WIDTH'(1);
            end else begin
               tc_d  = 1'b1;
               cnt_d = sat_i ? '0 : MAX_VAL;
            end
         end
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Scan prescaler and digit index; the segment pattern follows the new index.
   always_comb begin
      presc_d = presc_q + PRE_W'(1);
      idx_d   = idx_q;
      if (presc_q == PRE_W'(SCAN_DIV - 1)) begin
         presc_d = '0;
         if (idx_q == IDX_W'(DIGITS - 1)) begin
            idx_d = '0;
         end else begin
            idx_d = idx_q + IDX_W'(1);
         end
      end else begin
         idx_d = idx_q;
      end
      dig_sel_d = '0;
      dig_sel_d[idx_d] = 1'b1;
      padded_s = NIB_W'(cnt_q);
      nibble_s = padded_s[idx_d*4 +: 4];
      sseg_d   = hex_to_sseg(nibble_s);
`ifdef SSEG_LEADING_BLANK_EN
      if ((idx_d != '0) && ((padded_s >> (idx_d * 4)) == '0)) begin
         sseg_d = 8'b00000000;
      end else begin
         sseg_d = hex_to_sseg(nibble_s);
      end
`endif
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         cnt_q     <= '0;
         tc_q      <= 1'b0;
         presc_q   <= '0;
         idx_q     <= '0;
         dig_sel_q <= DIGITS'(1);
         sseg_q    <= 8'b11111100;
      end else begin
         cnt_q     <= cnt_d;
         tc_q      <= tc_d;
         presc_q   <= presc_d;
         idx_q     <= idx_d;
         dig_sel_q <= dig_sel_d;
         sseg_q    <= sseg_d;
      end
   end

   assign cnt_o     = cnt_q;
   assign tc_o      = tc_q;
   assign dig_sel_o = dig_sel_q;
   assign sseg_o    = sseg_q;

endmodule

// File: tb/tb_updown_counter_mux_sseg.sv
// Directed bench: three counters (MAX 255, 99, 150) share stimulus; scan checked on the first.
module tb_updown_counter_mux_sseg;

   logic       clk_s = 1'b0;
   logic       rst_n_s = 1'b0;
   logic       enable_s = 1'b0;
   logic       mode_s = 1'b1;
   logic       sat_s = 1'b0;
   logic       load_en_s = 1'b0;
   logic [7:0] load_s = 8'h00;

   logic [7:0] cnt_a_s, cnt_b_s, cnt_c_s;
   logic       tc_a_s, tc_b_s, tc_c_s;
   logic [1:0] dig_a_s, dig_b_s, dig_c_s;
   logic [7:0] sseg_a_s, sseg_b_s, sseg_c_s;

   int checks_s = 0;
   int errors_s = 0;

`ifdef SSEG_LEADING_BLANK_EN
   localparam logic [7:0] LEAD0 = 8'b00000000;
`else
   localparam logic [7:0] LEAD0 = 8'b11111100;
`endif

   always #5 clk_s = ~clk_s;

   updown_counter_mux_sseg #(.WIDTH(8), .MAX_VAL(8'd255), .DIGITS(2), .SCAN_DIV(4)) u_a (
      .clk_i(clk_s), .rst_ni(rst_n_s), .enable_i(enable_s), .mode_i(mode_s), .sat_i(sat_s),
      .load_en_i(load_en_s), .load_i(load_s), .cnt_o(cnt_a_s), .tc_o(tc_a_s),
      .dig_sel_o(dig_a_s), .sseg_o(sseg_a_s));

   updown_counter_mux_sseg #(.WIDTH(8), .MAX_VAL(8'd99), .DIGITS(2), .SCAN_DIV(4)) u_b (
      .clk_i(clk_s), .rst_ni(rst_n_s), .enable_i(enable_s), .mode_i(mode_s), .sat_i(sat_s),
      .load_en_i(load_en_s), .load_i(load_s), .cnt_o(cnt_b_s), .tc_o(tc_b_s),
      .dig_sel_o(dig_b_s), .sseg_o(sseg_b_s));

   updown_counter_mux_sseg #(.WIDTH(8), .MAX_VAL(8'd150), .DIGITS(2), .SCAN_DIV(4)) u_c (
      .clk_i(clk_s), .rst_ni(rst_n_s), .enable_i(enable_s), .mode_i(mode_s), .sat_i(sat_s),
      .load_en_i(load_en_s), .load_i(load_s), .cnt_o(cnt_c_s), .tc_o(tc_c_s),
      .dig_sel_o(dig_c_s), .sseg_o(sseg_c_s));

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks_s++;
      if (obs !== exp) begin
         errors_s++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_s);
      @(negedge clk_s);
   endtask

   initial begin
      // Reset
      @(negedge clk_s);
      rst_n_s = 1'b0;
      step();
      check_val("rst_cnt", 32'(cnt_a_s), 32'h0);
      check_val("rst_tc", 32'(tc_a_s), 32'h0);
      check_val("rst_dig", 32'(dig_a_s), 32'h1);
      check_val("rst_sseg", 32'(sseg_a_s), 32'hFC);

      // Load above modulus clamps; load beats enable
      rst_n_s = 1'b1; load_en_s = 1'b1; load_s = 8'hFE; enable_s = 1'b1;
      step();
      check_val("ld_a", 32'(cnt_a_s), 32'hFE);
      check_val("ld_b", 32'(cnt_b_s), 32'd99);
      check_val("ld_c", 32'(cnt_c_s), 32'd150);
      check_val("ld_tc", 32'(tc_a_s), 32'h0);

      // Up wrap
      load_en_s = 1'b0; mode_s = 1'b1; sat_s = 1'b0;
      step();
      check_val("up1_a", 32'(cnt_a_s), 32'hFF);
      check_val("up1_tca", 32'(tc_a_s), 32'h0);
      check_val("up1_b", 32'(cnt_b_s), 32'h0);
      check_val("up1_tcb", 32'(tc_b_s), 32'h1);
      check_val("up1_c", 32'(cnt_c_s), 32'h0);
      step();
      check_val("up2_a", 32'(cnt_a_s), 32'h0);
      check_val("up2_tca", 32'(tc_a_s), 32'h1);
      check_val("up2_b", 32'(cnt_b_s), 32'h1);
      check_val("up2_tcb", 32'(tc_b_s), 32'h0);
      step();
      check_val("up3_a", 32'(cnt_a_s), 32'h1);
      check_val("up3_tca", 32'(tc_a_s), 32'h0);

      // Down saturate from 1
      load_en_s = 1'b1; load_s = 8'h01;
      step();
      load_en_s = 1'b0; mode_s = 1'b0; sat_s = 1'b1;
      step();
      check_val("dn1_b", 32'(cnt_b_s), 32'h0);
      check_val("dn1_tc", 32'(tc_b_s), 32'h0);
      step();
      check_val("dn2_b", 32'(cnt_b_s), 32'h0);
      check_val("dn2_tc", 32'(tc_b_s), 32'h1);
      step();
      check_val("dn3_b", 32'(cnt_b_s), 32'h0);
      check_val("dn3_tc", 32'(tc_b_s), 32'h1);

      // Down wrap from 0, then immediate switch to up-saturate at the max
      sat_s = 1'b0;
      step();
      check_val("dw_a", 32'(cnt_a_s), 32'hFF);
      check_val("dw_tca", 32'(tc_a_s), 32'h1);
      check_val("dw_b", 32'(cnt_b_s), 32'd99);
      check_val("dw_c", 32'(cnt_c_s), 32'd150);
      mode_s = 1'b1; sat_s = 1'b1;
      step();
      check_val("us_a", 32'(cnt_a_s), 32'hFF);
      check_val("us_tca", 32'(tc_a_s), 32'h1);
      check_val("us_b", 32'(cnt_b_s), 32'd99);
      check_val("us_tcb", 32'(tc_b_s), 32'h1);

      // Load with and without enable
      enable_s = 1'b0; load_en_s = 1'b1; load_s = 8'hC8; mode_s = 1'b0;
      step();
      check_val("lc_c", 32'(cnt_c_s), 32'd150);
      check_val("lc_tc", 32'(tc_c_s), 32'h0);
      check_val("lc_a", 32'(cnt_a_s), 32'hC8);
      enable_s = 1'b1;
      step();
      check_val("lce_c", 32'(cnt_c_s), 32'd150);
      check_val("lce_tc", 32'(tc_c_s), 32'h0);
      check_val("lce_a", 32'(cnt_a_s), 32'hC8);

      // Reset mid-count and mid-scan
      load_en_s = 1'b0; mode_s = 1'b1; sat_s = 1'b0;
      step();
      rst_n_s = 1'b0;
      step();
      check_val("mr_cnt", 32'(cnt_a_s), 32'h0);
      check_val("mr_tc", 32'(tc_a_s), 32'h0);
      check_val("mr_dig", 32'(dig_a_s), 32'h1);
      check_val("mr_sseg", 32'(sseg_a_s), 32'hFC);

      // Scan of 0x3A: edge 1 after reset loads, digit 1 selected from edge 4
      rst_n_s = 1'b1; enable_s = 1'b0; load_en_s = 1'b1; load_s = 8'h3A;
      step();
      check_val("s1_cnt", 32'(cnt_a_s), 32'h3A);
      check_val("s1_sseg", 32'(sseg_a_s), 32'hFC);
      load_en_s = 1'b0;
      step();
      check_val("s2_dig", 32'(dig_a_s), 32'h1);
      check_val("s2_sseg", 32'(sseg_a_s), 32'hEE);
      step();
      check_val("s3_dig", 32'(dig_a_s), 32'h1);
      step();
      check_val("s4_dig", 32'(dig_a_s), 32'h2);
      check_val("s4_sseg", 32'(sseg_a_s), 32'hF2);
      step();
      step();
      step();
      check_val("s7_dig", 32'(dig_a_s), 32'h2);
      load_en_s = 1'b1; load_s = 8'h05;
      step();
      check_val("s8_dig", 32'(dig_a_s), 32'h1);
      check_val("s8_sseg", 32'(sseg_a_s), 32'hEE);
      load_en_s = 1'b0;
      step();
      check_val("s9_sseg", 32'(sseg_a_s), 32'hB6);
      step();
      step();
      load_en_s = 1'b1; load_s = 8'h00;
      step();
      check_val("s12_dig", 32'(dig_a_s), 32'h2);
      check_val("s12_sseg", 32'(sseg_a_s), 32'(LEAD0));
      load_en_s = 1'b0;
      step();
      step();
      step();
      check_val("s15_sseg", 32'(sseg_a_s), 32'(LEAD0));
      step();
      check_val("s16_dig", 32'(dig_a_s), 32'h1);
      check_val("s16_sseg", 32'(sseg_a_s), 32'hFC);

      $display("CHECKS %0d ERRORS %0d", checks_s, errors_s);
      $finish;
   end

endmodule

// File: doc/updown_counter_mux_sseg.md
Name: updown_counter_mux_sseg

Overview:
Parametrised up/down counter with synchronous load, programmable modulus, and wrap or saturate mode. Drives a time-multiplexed multi-digit seven-segment display, one hex nibble per digit. It is the multi-digit successor of the single-digit 4-bit counter/decoder and sits between the board switches/buttons and the display pins.

Parameters:
WIDTH, 8, counter width in bits (1..32)
MAX_VAL, 2**WIDTH-1, terminal value; the count range is 0..MAX_VAL
DIGITS, 2, number of display digits; must be >= ceil(WIDTH/4)
SCAN_DIV, 16, clock cycles each digit stays selected (>= 2)

Ports:
clk  input  1  rising-edge clock
rst  input  1  reset, active-low, synchronous
enable  input  1  count enable
mode  input  1  1 = count up, 0 = count down
sat  input  1  1 = saturate at bounds, 0 = wrap
load_en  input  1  synchronous load strobe
load  input  WIDTH  load value
cnt  output  WIDTH  current count (registered)
tc  output  1  terminal-count pulse (registered)
dig_sel  output  DIGITS  one-hot digit select, active-high, bit 0 = least-significant digit
sseg  output  8  segments {a,b,c,d,e,f,g,dp}, active-high, dp always 0

Behaviour:
- Reset: one clock, one active-low synchronous reset (clk, rst); all state updates on the rising edge of clk.
- Reset values: cnt=0, tc=0, scan prescaler=0, digit index=0, dig_sel=1, sseg=8'b11111100.
- Counter priority per edge:
  - !rst
  - then load_en
  - then enable
  - otherwise hold.
- load_en acts regardless of enable. A load value above MAX_VAL loads MAX_VAL. tc stays 0 on a load cycle.
- Up step: cnt<MAX_VAL gives cnt+1. At MAX_VAL, wrap to 0 (sat=0) or hold MAX_VAL (sat=1).
- Down step: cnt>0 gives cnt-1. At 0, wrap to MAX_VAL (sat=0) or hold 0 (sat=1).
- tc: goes high for exactly one cycle, on the edge that takes an enabled step from the boundary (up from MAX_VAL, down from 0), in both wrap and sat modes. Otherwise tc=0.
- mode and sat are sampled every edge. A change takes effect on the very next step, with no pipeline.
- Scan:
  - The prescaler counts 0..SCAN_DIV-1. When it reaches SCAN_DIV-1 it returns to 0, and the digit index advances modulo DIGITS.
  - dig_sel = one-hot of the digit index.
  - Scan runs independently of enable and load_en. Only reset restarts it.
- sseg is registered on the same edge as dig_sel. It decodes nibble[digit index] of the cnt value present before that edge, so there is one cycle of latency from cnt to sseg. Nibbles above WIDTH are zero-padded.
- Hex decode, 0..F: 11111100, 01100000, 11011010, 11110010, 01100110, 10110110, 10111110, 11100000, 11111110, 11110110, 11101110, 00111110, 00011010, 01111010, 10011110, 10001110.
- Reset mid-scan: next edge gives the reset values above. The first digit change comes SCAN_DIV cycles after rst is released.

Optional Feature:
Macro: SSEG_LEADING_BLANK_EN.
- Defined: sseg=8'b00000000 for any digit whose nibble is 0 and all of whose higher nibbles are also 0. Digit 0 is never blanked, so a value of 0 shows a single "0". dig_sel is unaffected.
- Undefined: every digit always shows its hex pattern, including leading zeros.

Test Plan:
- WIDTH=8, MAX_VAL=255, mode=1, sat=0, enable=1, cnt=254: after 2 edges, cnt=0, and tc=1 on the 255->0 edge only.
- MAX_VAL=99, mode=0, sat=1, cnt=1: edges give cnt=0, then 0 with tc=1, then 0 with tc=1.
- enable=0, load_en=1, load=8'hC8 with MAX_VAL=150: cnt=150 next edge, tc=0. A simultaneous enable=1 does not change the result.
- cnt=8'h3A, SCAN_DIV=4, DIGITS=2: dig_sel toggles 01/10 every 4 cycles; sseg=11101110 ("A") with dig_sel=01 and 11110010 ("3") with dig_sel=10.
- rst=0 for 1 edge mid-count and mid-scan: next edge gives cnt=0, tc=0, dig_sel=01, sseg=11111100. The first dig_sel change follows after SCAN_DIV cycles.
- SSEG_LEADING_BLANK_EN defined, cnt=8'h05: digit 1 gives sseg=0, digit 0 gives 10110110. With cnt=0, digit 0 gives 11111100.
